// File: rtl/jt_audio_pkg.sv
// Shared constants and scheduler state encoding for the audio mixing path.
package jt_audio_pkg;

    localparam int SAMPLE_W = 16;
    localparam int ACC_W    = 20;
    localparam int GAIN_MAX = 256;
    localparam logic [15:0] DAC_MID = 16'h8000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        SAT  = 2'd2,
        OUT  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/sample_hold_slot.sv
// One source's holding register, full flag and last-consumed value.
// Handshake: a sample transfers on a cycle where valid and ready are both high;
// ready is simply the inverse of the registered full flag.
module sample_hold_slot
    import jt_audio_pkg::*;
(
    input  logic                clk,
    input  logic                n_reset,
    input  logic                valid,
    input  logic [SAMPLE_W-1:0] data,
    input  logic                consume,
    output logic                ready,
    output logic                full,
    output logic [SAMPLE_W-1:0] value
);

    logic [SAMPLE_W-1:0] hold;
    logic [SAMPLE_W-1:0] last;

    assign ready = ~full;
    // An empty slot hands out the previous sample so the mix holds steady on underrun.
    assign value = full ? hold : last;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            hold <= '0;
            last <= '0;
            full <= 1'b0;
        end else if (consume && full) begin
            last <= hold;
            full <= 1'b0;
        end else if (valid && !full) begin
            hold <= data;
            full <= 1'b1;
        end
    end

endmodule

// File: rtl/dac_sample_sched.sv
// Frame-rate mixer: sums NSRC attenuated samples, saturates, applies the mute
// ramp gain and presents an offset-binary word to the DAC once per frame.
module dac_sample_sched
    import jt_audio_pkg::*;
#(
    parameter int NSRC = 2,
    parameter int DIV  = 1024
) (
    input  logic                     clk,
    input  logic                     n_reset,
    input  logic [NSRC-1:0]          src_valid,
    input  logic [SAMPLE_W*NSRC-1:0] src_data,
    output logic [NSRC-1:0]          src_ready,
    input  logic [3*NSRC-1:0]        src_shift,
    input  logic                     mute,
    output logic [15:0]              din,
    output logic                     din_stb,
    output logic                     clip,
    output logic                     underrun,
    output logic [1:0]               dbg_state
);

    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int IDX_W = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam logic signed [ACC_W-1:0] POS_LIM = 32767;
    localparam logic signed [ACC_W-1:0] NEG_LIM = -32768;

    sched_state_t             state;
    logic [CNT_W-1:0]         cnt;
    logic                     tick;
    logic [IDX_W-1:0]         idx;
    logic signed [ACC_W-1:0]  acc;
    logic signed [15:0]       sat;
    logic [8:0]               gain;

    logic [NSRC-1:0]          full;
    logic [NSRC-1:0]          consume;
    logic [SAMPLE_W-1:0]      slot_val [NSRC];
    logic [2:0]               shift_a  [NSRC];

    logic [SAMPLE_W-1:0]      cur_val;
    logic [2:0]               cur_shift;
    logic signed [ACC_W-1:0]  cur_ext;
    logic signed [ACC_W-1:0]  cur_term;
    logic signed [23:0]       sat_x;
    logic signed [23:0]       gain_x;
    logic signed [23:0]       prod;
    logic [15:0]              y;
    logic [7:0]               prod_frac_unused;

    assign dbg_state = state;
    assign tick      = (cnt == CNT_W'(DIV - 1));

    for (genvar i = 0; i < NSRC; i++) begin : g_slot
        assign consume[i] = (state == ACC) && (idx == IDX_W'(i));
        assign shift_a[i] = src_shift[3*i +: 3];

        sample_hold_slot u_slot (
            .clk     (clk),
            .n_reset (n_reset),
            .valid   (src_valid[i]),
            .data    (src_data[SAMPLE_W*i +: SAMPLE_W]),
            .consume (consume[i]),
            .ready   (src_ready[i]),
            .full    (full[i]),
            .value   (slot_val[i])
        );
    end

    assign cur_val   = slot_val[idx];
    assign cur_shift = shift_a[idx];
    assign cur_ext   = {{(ACC_W-SAMPLE_W){cur_val[SAMPLE_W-1]}}, cur_val};
    assign cur_term  = cur_ext >>> cur_shift;

    // 24 bits hold the full product exactly since |sat * gain| <= 2^23.
    assign sat_x  = {{8{sat[15]}}, sat};
    assign gain_x = $signed({15'd0, gain});
    assign prod   = sat_x * gain_x;
    assign {y, prod_frac_unused} = prod;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state    <= IDLE;
            idx      <= '0;
            acc      <= '0;
            sat      <= '0;
            gain     <= '0;
            din      <= DAC_MID;
            din_stb  <= 1'b0;
            clip     <= 1'b0;
            underrun <= 1'b0;
        end else begin
            din_stb <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick) begin
                        state <= ACC;
                        idx   <= '0;
                        acc   <= '0;
                        if (!(&full)) underrun <= 1'b1;
                    end
                end
                ACC: begin
                    acc <= acc + cur_term;
                    if (idx == IDX_W'(NSRC - 1)) begin
                        state <= SAT;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                SAT: begin
                    if (acc > POS_LIM) begin
                        sat  <= 16'sh7fff;
                        clip <= 1'b1;
                    end else if (acc < NEG_LIM) begin
                        sat  <= 16'sh8000;
                        clip <= 1'b1;
                    end else begin
                        sat <= acc[15:0];
                    end
                    state <= OUT;
                end
                OUT: begin
                    din     <= y ^ DAC_MID;
                    din_stb <= 1'b1;
                    // Product above used the pre-update gain; one step per frame.
                    if (mute) begin
                        if (gain != 9'd0) gain <= gain - 1'b1;
                    end else begin
                        if (gain != 9'(GAIN_MAX)) gain <= gain + 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/dac_sample_sched.md
# dac_sample_sched

Frame scheduler and mixer that feeds the hybrid PWM/sigma-delta audio DAC. It collects one signed 16-bit sample per frame from each of NSRC sound sources over valid/ready handshakes, then sums them with per-source attenuation and saturation. A mute ramp is applied, and the result is presented to the DAC as an offset-binary `din` word at a fixed frame rate. It sits between the core's sound chips and the DAC instance, one per audio channel.

## Interface
- `NSRC`, 2: number of sample sources (1..8).
- `DIV`, 1024: clock cycles per output frame; must be ≥ NSRC+4.
- `clk`  in  1  system clock, the same clock as the DAC.
- `n_reset`  in  1  asynchronous, active-low reset.
- `src_valid`  in  NSRC  source i has a sample on `src_data` slice i.
- `src_data`  in  16*NSRC  signed two's-complement samples; slice i is bits [16i+15:16i].
- `src_ready`  out  NSRC  holding register i is empty.
- `src_shift`  in  3*NSRC  per-source arithmetic right-shift attenuation, 0..7.
- `mute`  in  1  level; ramps the output to mid-scale while high.
- `din`  out  16  unsigned offset-binary word to the DAC.
- `din_stb`  out  1  one-cycle pulse when `din` updates.
- `clip`  out  1  sticky; the mix saturated at least once.
- `underrun`  out  1  sticky; a frame started with some holding register empty.

## Operation
- Frame counter counts 0..DIV-1 and wraps. The frame tick is asserted when the count is DIV-1.
- Per source, a 16-bit holding register plus a `full` flag:
  - `src_ready[i] = ~full[i]` (combinational from the flop).
  - On `valid & ready`, the register captures the sample and `full` is set.
  - The ACC stage clears `full` when it consumes entry i.
- If a source's register is empty at the tick, the last consumed value for that source is reused and `underrun` is set.
- FSM states:
  - IDLE → ACC on tick.
  - ACC lasts NSRC cycles, index i = 0..NSRC-1. Each cycle: `acc += sext(hold[i]) >>> shift[i]`. `acc` is 20-bit signed and cleared on IDLE→ACC.
  - SAT, 1 cycle: clamp `acc` to [-32768, 32767]. Set `clip` if a clamp occurred.
  - OUT, 1 cycle: `y = (sat * gain) >>> 8`, where `gain` is 9-bit unsigned 0..256. Then `din <= y ^ 16'h8000` and `din_stb <= 1`.
  - OUT → IDLE.
- Mute ramp, updated once per frame in OUT:
  - `mute` = 1: `gain` decrements by 1 toward 0.
  - `mute` = 0: `gain` increments by 1 toward 256.
  - Full ramp is 256 frames. The product uses the gain value before the update.
- A tick that arrives while the FSM is not in IDLE is ignored. This is impossible when DIV ≥ NSRC+4.
- `clip` and `underrun` clear only on reset.

## Timing
- Reset values:
  - `din` = 16'h8000 (mid-scale); `din_stb` = 0; `clip` = 0; `underrun` = 0.
  - `src_ready` = all 1s; `full` = 0; last-consumed values = 0.
  - `gain` = 0, so power-up ramps in without a click; frame counter = 0; FSM = IDLE.
- First tick is DIV-1 cycles after reset release.
- Latency from tick to `din_stb`: NSRC+2 cycles (ACC × NSRC, SAT, OUT). `din` is registered and stable for the rest of the frame.
- A source consumed in ACC sees `src_ready` high on the next cycle. Acceptance needs `ready` high in the same cycle as `valid`, so there is no accept in the consume cycle itself.
- Asserting reset mid-frame aborts the frame immediately: outputs take their reset values and no `din_stb` is issued.
- `mute` is sampled only in OUT; it needs no synchroniser beyond being in the `clk` domain.

## Structure
- Shared package `jt_audio_pkg`:
  - constants `SAMPLE_W` = 16, `ACC_W` = 20, `GAIN_MAX` = 256, `DAC_MID` = 16'h8000;
  - enum `sched_state_t` {IDLE, ACC, SAT, OUT}.
- One natural sub-module, `sample_hold_slot`: holding register, `full` flag, last-value register and ready logic, generated NSRC times.
- The top level holds the frame counter, FSM, accumulator, saturation and gain.

## Test plan
- Ramp-in after reset: NSRC=2, DIV=16, both sources hold 16'h4000 with shift 0, `mute` = 0.
  - `din` = 16'h8000 at reset; the first frame also emits 8000 (gain 0).
  - `din` then rises monotonically and reaches 16'hFFFF (saturated 32767 ^ 8000) once `gain` = 256.
  - `clip` sets on the first frame.
- Steady mix with shift: after the ramp completes, src0 = 1000 with shift 1, src1 = -200 with shift 0. Expect `din` = 16'h812C (300 + 32768) and `din_stb` 4 cycles after the tick.
- Negative saturation: two sources at -32768, shift 0, gain at 256. Expect `din` = 16'h0000 and `clip` = 1.
- Underrun hold: src1 stops asserting `valid` after one sample of 500. Its value 500 is reused each frame and `underrun` sets at the next tick.
- Handshake: hold `src_valid[0]` = 1 continuously. Expect exactly one accept per frame, and `src_ready[0]` low from accept until the cycle after its ACC slot.
- Mute and reset abort: assert `mute`; `din` reaches 16'h8000 after 256 frames. Then pulse `n_reset` low mid-ACC: no `din_stb` is issued and all outputs return to reset values immediately.
